sensor_scheduler: RTL and testbench
===================================

# sensor_scheduler

Sequences the two range/environment sensor controllers (SR04, DHT11) that share the 1 µs tick and the display/report path. It merges periodic auto-poll timers with one-shot requests from control policy (button/UART), and enforces that only one sensor measures at a time. It also applies a per-sensor timeout and a DHT11 minimum re-read interval. It sits between `control_unit` (request pulses) and `sr04_controller` / `dht11_controller` (start pulses, valid strobes).

## Interface
- P_SR04_PERIOD_MS, 100: auto-poll interval for SR04 (ms).
- P_DHT11_PERIOD_MS, 2000: auto-poll interval for DHT11 (ms).
- P_DHT11_MIN_MS, 1000: minimum start-to-start spacing for DHT11 (ms).
- P_SR04_TIMEOUT_MS, 60: max SR04 measurement window (ms).
- P_DHT11_TIMEOUT_MS, 30: max DHT11 measurement window (ms).
- P_GAP_MS, 2: idle spacing after any measurement ends (ms, ≥1).

Ports:
- iClk  in  1  system clock, 100 MHz.
- iRst  in  1  reset, synchronous, active-low.
- iTick1kHz  in  1  one-cycle 1 ms tick.
- iAutoEn  in  1  enables periodic polling; requests are served regardless.
- iReqSr04  in  1  one-cycle SR04 request pulse.
- iReqDht11  in  1  one-cycle DHT11 request pulse.
- iSr04Done  in  1  SR04 distance-valid strobe.
- iDht11Done  in  1  DHT11 data-valid strobe.
- oSr04Start  out  1  one-cycle start pulse to SR04 controller.
- oDht11Start  out  1  one-cycle start pulse to DHT11 controller.
- oActive  out  2  {DHT11 running, SR04 running}; at most one bit set.
- oSr04Timeout  out  1  one-cycle pulse, SR04 window expired.
- oDht11Timeout  out  1  one-cycle pulse, DHT11 window expired.
- oSr04Stale  out  1  last SR04 attempt timed out.
- oDht11Stale  out  1  last DHT11 attempt timed out.

## Operation
- Pending flags rPendSr04/rPendDht11 are set by a request pulse or by period-timer expiry (only while iAutoEn=1). They are cleared when the matching start is issued.
- A request for the sensor currently running is discarded. A request for the other sensor sets its pending flag.
- DHT11 pending is eligible only when ≥P_DHT11_MIN_MS ticks have elapsed since the last DHT11 start. Otherwise it stays pending and is deferred, not dropped.
- FSM states: IDLE, RUN_SR04, RUN_DHT11, GAP.
  - IDLE: if both eligible, round-robin on rLastServed (reset = DHT11, so SR04 goes first). On entry to RUN_x, pulse oXStart, set oActive, clear the run-ms counter and restart that sensor's period timer.
  - RUN_x on iXDone: go to GAP and clear oXStale.
  - RUN_x when the run counter reaches P_X_TIMEOUT_MS: pulse oXTimeout, set oXStale, go to GAP.
  - Done and timeout-reaching tick in the same cycle: done wins, no timeout pulse.
  - GAP: count P_GAP_MS ticks, then go to IDLE.
- Done strobes outside the matching RUN state are ignored.
- iAutoEn falling: period timers hold at 0 and existing pending flags are kept. Rising: timers start from 0.
- Counters are ms-granular, sized by $clog2(max param + 1), and saturate; no wrap.

## Timing
- Reset values:
  - all outputs 0 except oSr04Stale/oDht11Stale = 0;
  - state IDLE, pending 0, timers 0;
  - DHT11 min-interval counter preset to "satisfied".
- Request at cycle t in IDLE, other sensor idle: pending set at t+1, start pulse at t+2, oActive high from t+2.
- Done at t: oActive low at t+1, state GAP at t+1.
- Timeout measured in whole iTick1kHz pulses after start. Timeout pulse is in the cycle after the P_X_TIMEOUT_MS-th tick.
- Reset asserted mid-RUN: next cycle IDLE with all outputs 0. No start is emitted in the reset cycle.
- Request and period expiry for the same sensor in the same cycle: one pending, one start.

## Structure
- Package sensor_sched_pkg: state enum, sensor index constants (SENS_SR04=0, SENS_DHT11=1), and the counter-width function.
- Sub-module ms_interval_timer (tick-driven down counter with restart, hold and expire pulse), instantiated twice for the period timers. The run/gap counter and the DHT11 min-interval counter are inline.

## Test plan
- iAutoEn=0, iReqSr04 at t, iSr04Done 5 ms later → oSr04Start at t+2, oActive=01 for 5 ms, GAP 2 ms, back to IDLE. No timeout.
- iReqSr04 and iReqDht11 in the same cycle from reset → SR04 starts first. DHT11 starts exactly P_GAP_MS ticks after SR04 done. oActive never 11.
- DHT11 done, then iReqDht11 200 ms after its start → no start until 1000 ms after previous start, then exactly one oDht11Start.
- SR04 started, no done → oSr04Timeout pulse after 60 ticks and oSr04Stale=1. Next successful done clears oSr04Stale.
- iAutoEn=1 for 2.1 s with done returned after 1 ms → 20–21 SR04 starts and 1 DHT11 start. No overlap.
- Reset asserted while RUN_DHT11 → next cycle IDLE with all outputs 0. A late iDht11Done after reset is ignored.

Source files
------------

// File: rtl/sensor_scheduler_pkg.sv
// Shared types and helpers for the SR04/DHT11 measurement scheduler.
package sensor_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN_SR04  = 2'd1,
        ST_RUN_DHT11 = 2'd2,
        ST_GAP       = 2'd3
    } sched_state_t;

    localparam logic SENS_SR04  = 1'b0;
    localparam logic SENS_DHT11 = 1'b1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sensor_scheduler_ms_interval_timer.sv
// Millisecond down counter: re-arms on restart, parks at zero while held,
// and emits a one-cycle expire pulse every P_PERIOD_MS ticks.
module ms_interval_timer
    import sensor_sched_pkg::*;
#(
    parameter int P_PERIOD_MS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic restart,
    input  logic hold,
    output logic expire
);

    localparam int W = cnt_width(P_PERIOD_MS);
    localparam logic [W-1:0] PERIOD = W'(P_PERIOD_MS);

    logic [W-1:0] count_reg;

    // Zero means "not armed"; the first free-running cycle loads a full period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
            expire    <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (hold) begin
                count_reg <= '0;
            end else if (restart || count_reg == '0) begin
                count_reg <= PERIOD;
            end else if (tick) begin
                if (count_reg == W'(1)) begin
                    expire    <= 1'b1;
                    count_reg <= PERIOD;
                end else begin
                    count_reg <= count_reg - W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sensor_scheduler.sv
// Arbitrates SR04 and DHT11 measurements: one at a time, periodic plus
// on-demand requests, per-sensor timeout and DHT11 re-read spacing.
module sensor_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int P_SR04_PERIOD_MS   = 100,
    parameter int P_DHT11_PERIOD_MS  = 2000,
    parameter int P_DHT11_MIN_MS     = 1000,
    parameter int P_SR04_TIMEOUT_MS  = 60,
    parameter int P_DHT11_TIMEOUT_MS = 30,
    parameter int P_GAP_MS           = 2
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick1kHz,
    input  logic       iAutoEn,
    input  logic       iReqSr04,
    input  logic       iReqDht11,
    input  logic       iSr04Done,
    input  logic       iDht11Done,
    output logic       oSr04Start,
    output logic       oDht11Start,
    output logic [1:0] oActive,
    output logic       oSr04Timeout,
    output logic       oDht11Timeout,
    output logic       oSr04Stale,
    output logic       oDht11Stale
);

    localparam int RUN_W = cnt_width(max3(P_SR04_TIMEOUT_MS, P_DHT11_TIMEOUT_MS, P_GAP_MS));
    localparam int MIN_W = cnt_width(P_DHT11_MIN_MS);
    localparam logic [RUN_W-1:0] SR04_LAST  = RUN_W'(P_SR04_TIMEOUT_MS - 1);
    localparam logic [RUN_W-1:0] DHT11_LAST = RUN_W'(P_DHT11_TIMEOUT_MS - 1);
    localparam logic [RUN_W-1:0] GAP_LAST   = RUN_W'(P_GAP_MS - 1);
    localparam logic [MIN_W-1:0] MIN_DONE   = MIN_W'(P_DHT11_MIN_MS);
    localparam int PERIOD_MS [2] = '{P_SR04_PERIOD_MS, P_DHT11_PERIOD_MS};

    sched_state_t     state_reg;
    logic             pend_sr04_reg;
    logic             pend_dht11_reg;
    logic             last_served_reg;
    logic [RUN_W-1:0] run_cnt_reg;
    logic [MIN_W-1:0] dht_min_cnt_reg;

    logic       dht_min_ok;
    logic       sr04_elig;
    logic       dht11_elig;
    logic       go_sr04;
    logic       go_dht11;
    logic       set_sr04;
    logic       set_dht11;
    logic       timer_hold;
    logic [1:0] restart;
    logic [1:0] expire;

    assign dht_min_ok = (dht_min_cnt_reg == MIN_DONE);
    assign sr04_elig  = pend_sr04_reg;
    assign dht11_elig = pend_dht11_reg && dht_min_ok;

    // Round-robin only matters when both are eligible in the same IDLE cycle.
    assign go_sr04  = (state_reg == ST_IDLE) && sr04_elig &&
                      (!dht11_elig || last_served_reg == SENS_DHT11);
    assign go_dht11 = (state_reg == ST_IDLE) && dht11_elig &&
                      (!sr04_elig || last_served_reg == SENS_SR04);

    assign set_sr04  = (iReqSr04  | expire[0]) && (state_reg != ST_RUN_SR04);
    assign set_dht11 = (iReqDht11 | expire[1]) && (state_reg != ST_RUN_DHT11);

    assign timer_hold = ~iAutoEn;
    assign restart    = {go_dht11, go_sr04};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_period
            ms_interval_timer #(
                .P_PERIOD_MS(PERIOD_MS[gi])
            ) u_timer (
                .clk    (iClk),
                .rst_n  (iRst),
                .tick   (iTick1kHz),
                .restart(restart[gi]),
                .hold   (timer_hold),
                .expire (expire[gi])
            );
        end
    endgenerate

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_reg       <= ST_IDLE;
            pend_sr04_reg   <= 1'b0;
            pend_dht11_reg  <= 1'b0;
            last_served_reg <= SENS_DHT11;
            run_cnt_reg     <= '0;
            dht_min_cnt_reg <= MIN_DONE;
            oSr04Start      <= 1'b0;
            oDht11Start     <= 1'b0;
            oActive         <= 2'b00;
            oSr04Timeout    <= 1'b0;
            oDht11Timeout   <= 1'b0;
            oSr04Stale      <= 1'b0;
            oDht11Stale     <= 1'b0;
        end else begin
            oSr04Start    <= 1'b0;
            oDht11Start   <= 1'b0;
            oSr04Timeout  <= 1'b0;
            oDht11Timeout <= 1'b0;

            if (go_sr04)       pend_sr04_reg <= 1'b0;
            else if (set_sr04) pend_sr04_reg <= 1'b1;
            if (go_dht11)       pend_dht11_reg <= 1'b0;
            else if (set_dht11) pend_dht11_reg <= 1'b1;

            // Elapsed ms since the last DHT11 start, parked once satisfied.
            if (go_dht11)                     dht_min_cnt_reg <= '0;
            else if (iTick1kHz && !dht_min_ok) dht_min_cnt_reg <= dht_min_cnt_reg + MIN_W'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (go_sr04) begin
                        state_reg       <= ST_RUN_SR04;
                        oSr04Start      <= 1'b1;
                        oActive         <= 2'b01;
                        run_cnt_reg     <= '0;
                        last_served_reg <= SENS_SR04;
                    end else if (go_dht11) begin
                        state_reg       <= ST_RUN_DHT11;
                        oDht11Start     <= 1'b1;
                        oActive         <= 2'b10;
                        run_cnt_reg     <= '0;
                        last_served_reg <= SENS_DHT11;
                    end
                end
                ST_RUN_SR04: begin
                    if (iSr04Done) begin
                        state_reg   <= ST_GAP;
                        oActive     <= 2'b00;
                        oSr04Stale  <= 1'b0;
                        run_cnt_reg <= '0;
                    end else if (iTick1kHz) begin
                        if (run_cnt_reg == SR04_LAST) begin
                            state_reg    <= ST_GAP;
                            oActive      <= 2'b00;
                            oSr04Timeout <= 1'b1;
                            oSr04Stale   <= 1'b1;
                            run_cnt_reg  <= '0;
                        end else begin
                            run_cnt_reg <= run_cnt_reg + RUN_W'(1);
                        end
                    end
                end
                ST_RUN_DHT11: begin
                    if (iDht11Done) begin
                        state_reg   <= ST_GAP;
                        oActive     <= 2'b00;
                        oDht11Stale <= 1'b0;
                        run_cnt_reg <= '0;
                    end else if (iTick1kHz) begin
                        if (run_cnt_reg == DHT11_LAST) begin
                            state_reg     <= ST_GAP;
                            oActive       <= 2'b00;
                            oDht11Timeout <= 1'b1;
                            oDht11Stale   <= 1'b1;
                            run_cnt_reg   <= '0;
                        end else begin
                            run_cnt_reg <= run_cnt_reg + RUN_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (iTick1kHz) begin
                        if (run_cnt_reg == GAP_LAST) begin
                            state_reg   <= ST_IDLE;
                            run_cnt_reg <= '0;
                        end else begin
                            run_cnt_reg <= run_cnt_reg + RUN_W'(1);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler with a timestamp-based reference model.
module tb_sensor_scheduler;

    localparam int TDIV      = 5;
    localparam int SR_PER    = 100;
    localparam int DHT_PER   = 2000;
    localparam int DHT_MIN   = 1000;
    localparam int SR_TO     = 60;
    localparam int DHT_TO    = 30;
    localparam int GAP       = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, auto_en, req_sr, req_dht, done_sr, done_dht;
    logic       sr_start, dht_start, sr_to, dht_to, sr_stale, dht_stale;
    logic [1:0] active;

    sensor_scheduler dut (
        .iClk(clk), .iRst(rst), .iTick1kHz(tick), .iAutoEn(auto_en),
        .iReqSr04(req_sr), .iReqDht11(req_dht),
        .iSr04Done(done_sr), .iDht11Done(done_dht),
        .oSr04Start(sr_start), .oDht11Start(dht_start), .oActive(active),
        .oSr04Timeout(sr_to), .oDht11Timeout(dht_to),
        .oSr04Stale(sr_stale), .oDht11Stale(dht_stale)
    );

    int checks = 0, failures = 0;
    int cyc = 0, tick_count = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (tick) tick_count++;
    end

    initial begin
        int phase = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick  = (phase == 0);
            phase = (phase + 1) % TDIV;
        end
    end

    // ---------------- reference model (absolute ms timestamps) ----------------
    bit model_valid = 0;
    int m_ms, m_run, m_run_start, m_gap_start, m_last_dht;
    bit m_gap, m_pend_sr, m_pend_dht, m_dht_last;
    bit sr_armed, dht_armed, sr_exp, dht_exp;
    int sr_origin, dht_origin;
    bit e_sr_start, e_dht_start, e_sr_to, e_dht_to, e_sr_stale, e_dht_stale;
    logic [1:0] e_active;

    always @(posedge clk) begin
        int ms_pre;
        bit idle, sr_ok, dht_ok, go_sr, go_dht, nx_sr, nx_dht;
        if (!rst) begin
            model_valid = 1;
            m_run = 0; m_gap = 0; m_pend_sr = 0; m_pend_dht = 0; m_dht_last = 1;
            m_last_dht = -1000000; sr_armed = 0; dht_armed = 0; sr_exp = 0; dht_exp = 0;
            e_sr_start = 0; e_dht_start = 0; e_sr_to = 0; e_dht_to = 0;
            e_sr_stale = 0; e_dht_stale = 0; e_active = 2'b00;
        end else if (model_valid) begin
            ms_pre = m_ms;
            if (tick) m_ms++;
            idle   = (m_run == 0) && !m_gap;
            sr_ok  = m_pend_sr;
            dht_ok = m_pend_dht && (ms_pre - m_last_dht >= DHT_MIN);
            go_sr  = idle && sr_ok && (!dht_ok || m_dht_last);
            go_dht = idle && dht_ok && (!sr_ok || !m_dht_last);
            if (go_sr) m_pend_sr = 0;
            else if ((req_sr || sr_exp) && m_run != 1) m_pend_sr = 1;
            if (go_dht) m_pend_dht = 0;
            else if ((req_dht || dht_exp) && m_run != 2) m_pend_dht = 1;
            nx_sr = 0; nx_dht = 0;
            if (!auto_en) sr_armed = 0;
            else if (go_sr || !sr_armed) begin sr_armed = 1; sr_origin = m_ms; end
            else if (tick && m_ms - sr_origin >= SR_PER) begin nx_sr = 1; sr_origin = m_ms; end
            if (!auto_en) dht_armed = 0;
            else if (go_dht || !dht_armed) begin dht_armed = 1; dht_origin = m_ms; end
            else if (tick && m_ms - dht_origin >= DHT_PER) begin nx_dht = 1; dht_origin = m_ms; end
            sr_exp = nx_sr; dht_exp = nx_dht;
            e_sr_start = 0; e_dht_start = 0; e_sr_to = 0; e_dht_to = 0;
            if (go_sr) begin
                m_run = 1; m_run_start = m_ms; e_sr_start = 1; e_active = 2'b01; m_dht_last = 0;
            end else if (go_dht) begin
                m_run = 2; m_run_start = m_ms; m_last_dht = m_ms;
                e_dht_start = 1; e_active = 2'b10; m_dht_last = 1;
            end else if (m_run == 1) begin
                if (done_sr) begin
                    m_run = 0; m_gap = 1; m_gap_start = m_ms; e_active = 0; e_sr_stale = 0;
                end else if (tick && m_ms - m_run_start >= SR_TO) begin
                    m_run = 0; m_gap = 1; m_gap_start = m_ms; e_active = 0;
                    e_sr_stale = 1; e_sr_to = 1;
                end
            end else if (m_run == 2) begin
                if (done_dht) begin
                    m_run = 0; m_gap = 1; m_gap_start = m_ms; e_active = 0; e_dht_stale = 0;
                end else if (tick && m_ms - m_run_start >= DHT_TO) begin
                    m_run = 0; m_gap = 1; m_gap_start = m_ms; e_active = 0;
                    e_dht_stale = 1; e_dht_to = 1;
                end
            end else if (m_gap && tick && m_ms - m_gap_start >= GAP) begin
                m_gap = 0;
            end
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    int n_sr_start = 0, n_dht_start = 0, n_sr_to = 0, n_dht_to = 0, n_overlap = 0, n_fall = 0;
    int last_sr_start_tick, last_sr_start_cyc, last_dht_start_tick, last_sr_to_tick, last_fall_tick;
    logic [1:0] prev_active = 2'b00;

    always @(negedge clk) begin
        logic [7:0] dut_vec, exp_vec;
        dut_vec = {sr_start, dht_start, active, sr_to, dht_to, sr_stale, dht_stale};
        exp_vec = {e_sr_start, e_dht_start, e_active, e_sr_to, e_dht_to, e_sr_stale, e_dht_stale};
        if (model_valid) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL cycle_model cyc=%0d actual=%b expected=%b", cyc, dut_vec, exp_vec);
            end
        end
        if (active === 2'b11) n_overlap++;
        if (sr_start === 1'b1) begin n_sr_start++; last_sr_start_tick = tick_count; last_sr_start_cyc = cyc; end
        if (dht_start === 1'b1) begin n_dht_start++; last_dht_start_tick = tick_count; end
        if (sr_to === 1'b1) begin n_sr_to++; last_sr_to_tick = tick_count; end
        if (dht_to === 1'b1) n_dht_to++;
        if (prev_active != 2'b00 && active == 2'b00) begin n_fall++; last_fall_tick = tick_count; end
        prev_active = active;
    end

    // ---------------- sensor responder ----------------
    int sr_delay = 0, dht_delay = 0, sr_due, dht_due, sr_done_tick;
    bit sr_wait = 0, dht_wait = 0, force_dht_done = 0;

    initial begin
        done_sr = 1'b0; done_dht = 1'b0;
        forever begin
            step();
            done_sr = 1'b0; done_dht = 1'b0;
            if (sr_start && sr_delay > 0) begin sr_wait = 1; sr_due = tick_count + sr_delay; end
            else if (sr_wait && tick_count >= sr_due) begin
                done_sr = 1'b1; sr_wait = 0; sr_done_tick = tick_count;
            end
            if (dht_start && dht_delay > 0) begin dht_wait = 1; dht_due = tick_count + dht_delay; end
            else if (dht_wait && tick_count >= dht_due) begin done_dht = 1'b1; dht_wait = 0; end
            if (force_dht_done) begin done_dht = 1'b1; force_dht_done = 0; end
            if (!rst) begin sr_wait = 0; dht_wait = 0; end
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic int mon(input int sel);
        case (sel)
            0: return n_sr_start;
            1: return n_dht_start;
            2: return n_sr_to;
            default: return n_fall;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int target, input int budget, input string name);
        int k = 0;
        while (mon(sel) < target && k < budget) begin step(); k++; end
        if (mon(sel) < target) begin
            checks++; failures++;
            $display("FAIL %s timeout actual=%0d required=%0d", name, mon(sel), target);
        end
    endtask

    task automatic wait_ticks(input int n);
        int t0 = tick_count;
        int k = 0;
        while (tick_count < t0 + n && k < n * TDIV + 20) begin step(); k++; end
    endtask

    task automatic wait_tick_edge();
        wait_ticks(1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0; step(); step(); rst = 1'b1; step();
    endtask

    initial begin
        int c0, f0, s0, d0, t0, sd, nsr, ndht;
        rst = 1'b0; auto_en = 1'b0; req_sr = 1'b0; req_dht = 1'b0;
        repeat (3) step();
        check("reset_outputs", int'({sr_start, dht_start, active, sr_to, dht_to}), 0);
        check("reset_stale", int'({sr_stale, dht_stale}), 0);
        rst = 1'b1;
        repeat (3) step();

        // single SR04 request, 5 ms measurement
        sr_delay = 5;
        wait_tick_edge();
        req_sr = 1'b1; c0 = cyc; step(); req_sr = 1'b0;
        wait_until(0, 1, 20, "t1_start");
        check("t1_start_latency", last_sr_start_cyc - c0, 2);
        check("t1_active_sr", int'(active), 1);
        f0 = n_fall;
        wait_until(3, f0 + 1, 20 * TDIV, "t1_done");
        check("t1_active_ms", last_fall_tick - last_sr_start_tick, 5);
        check("t1_no_timeout", n_sr_to, 0);
        check("t1_stale", int'(sr_stale), 0);
        wait_ticks(5);

        // simultaneous requests from reset: SR04 first, DHT11 after the gap
        pulse_reset();
        sr_delay = 3; dht_delay = 5;
        s0 = n_sr_start; d0 = n_dht_start;
        wait_tick_edge();
        req_sr = 1'b1; req_dht = 1'b1; step(); req_sr = 1'b0; req_dht = 1'b0;
        wait_until(0, s0 + 1, 20, "t2_sr_start");
        check("t2_dht_not_first", n_dht_start - d0, 0);
        wait_until(1, d0 + 1, 20 * TDIV, "t2_dht_start");
        check("t2_gap_ms", last_dht_start_tick - sr_done_tick, GAP);
        wait_ticks(10);

        // DHT11 re-request 200 ms after its start is deferred to the 1000 ms mark
        sd = last_dht_start_tick;
        while (tick_count < sd + 200) step();
        d0 = n_dht_start;
        req_dht = 1'b1; step(); req_dht = 1'b0;
        wait_until(1, d0 + 1, 900 * TDIV, "t3_dht_start");
        check("t3_min_interval", last_dht_start_tick - sd, DHT_MIN);
        wait_ticks(100);
        check("t3_one_start", n_dht_start - d0, 1);

        // SR04 with no answer times out, next good answer clears stale
        sr_delay = 0;
        wait_tick_edge();
        t0 = n_sr_to;
        req_sr = 1'b1; step(); req_sr = 1'b0;
        wait_until(2, t0 + 1, 70 * TDIV, "t4_timeout");
        check("t4_timeout_ms", last_sr_to_tick - last_sr_start_tick, SR_TO);
        check("t4_stale_set", int'(sr_stale), 1);
        check("t4_dht_stale", int'(dht_stale), 0);
        sr_delay = 2;
        wait_ticks(5);
        f0 = n_fall;
        req_sr = 1'b1; step(); req_sr = 1'b0;
        wait_until(3, f0 + 1, 10 * TDIV, "t4_done");
        step();
        check("t4_stale_clear", int'(sr_stale), 0);
        check("t4_single_timeout", n_sr_to - t0, 1);

        // periodic polling for 2100 ms
        pulse_reset();
        sr_delay = 1; dht_delay = 1;
        s0 = n_sr_start; d0 = n_dht_start; t0 = tick_count;
        auto_en = 1'b1;
        wait_ticks(2100);
        nsr = n_sr_start - s0; ndht = n_dht_start - d0;
        auto_en = 1'b0;
        wait_ticks(100);
        check("t5_sr_starts_20_21", int'(nsr >= 20 && nsr <= 21), 1);
        check("t5_dht_starts", ndht, 1);
        check("t5_no_overlap", n_overlap, 0);
        check("t5_no_timeouts", n_sr_to + n_dht_to, 1);

        // reset in the middle of a DHT11 run, late done ignored
        pulse_reset();
        dht_delay = 0;
        d0 = n_dht_start;
        wait_tick_edge();
        req_dht = 1'b1; step(); req_dht = 1'b0;
        wait_until(1, d0 + 1, 20, "t6_dht_start");
        wait_ticks(3);
        check("t6_active_dht", int'(active), 2);
        rst = 1'b0; step();
        check("t6_reset_outputs", int'({sr_start, dht_start, active, sr_to, dht_to, sr_stale, dht_stale}), 0);
        rst = 1'b1; step();
        force_dht_done = 1;
        t0 = n_dht_to;
        wait_ticks(40);
        check("t6_idle_after_reset", int'(active), 0);
        check("t6_no_new_start", n_dht_start - d0, 1);
        check("t6_no_timeout", n_dht_to - t0, 0);
        check("t6_stale", int'(dht_stale), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
